// File: rtl/raiz_entera_param_if.sv
// Handshake and result bundle for the iterative integer square-root unit.
// The master side issues START/OPERAND/ABORT and watches BUSY/DONE and the
// registered results; the slave side is the root engine itself.
interface raiz_entera_param_if #(
    parameter int WIDTH = 16
);
    logic                 START;
    logic [WIDTH-1:0]     OPERAND;
    logic                 ABORT;
    logic                 BUSY;
    logic                 DONE;
    logic [WIDTH/2-1:0]   ROOT;
    logic [WIDTH/2:0]     REM;
    logic                 EXACT;
    logic                 SAT;

    modport master (
        output START, OPERAND, ABORT,
        input  BUSY, DONE, ROOT, REM, EXACT, SAT
    );

    modport slave (
        input  START, OPERAND, ABORT,
        output BUSY, DONE, ROOT, REM, EXACT, SAT
    );
endinterface

// File: rtl/raiz_entera_param.sv
// Iterative integer square root, one radix-4 restoring step per cycle.
// Handshake: START is sampled only while idle (BUSY low) together with
// OPERAND; BUSY stays high until the result is published; DONE is a single
// cycle pulse coinciding with the first cycle the new ROOT/REM/EXACT/SAT are
// visible. ABORT drops an operation in flight without touching the results.
// fsm_state mirrors the controller state (IDLE=00 ITER=01 FIN=10 DONE=11).
module raiz_entera_param #(
    parameter int WIDTH = 16,
    parameter int ROUND = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    raiz_entera_param_if.slave   bus,
    output logic [1:0]           fsm_state
);
    localparam int H  = WIDTH / 2;
    localparam int RW = H + 2;
    localparam int CW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] opnd;
    logic [RW-1:0]   r;
    logic [H-1:0]    q;
    logic [CW-1:0]   cnt;

    logic [RW-1:0]   r_shift;
    logic [RW-1:0]   trial;
    logic [RW-1:0]   r_step;
    logic [H-1:0]    q_step;
    logic            round_up;
    logic            sat_fin;
    logic [H-1:0]    root_fin;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ABORT only matters while iterating or finishing.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.START) state_next = S_ITER;
            S_ITER: begin
                if (bus.ABORT)       state_next = S_IDLE;
                else if (cnt == '0)  state_next = S_FIN;
            end
            S_FIN:  state_next = bus.ABORT ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Controller outputs decoded from the current state.
    always_comb begin
        bus.BUSY  = (state != S_IDLE);
        bus.DONE  = (state == S_DONE);
        fsm_state = state;
    end

    // One restoring step: bring in the next operand bit pair, try q*4+1.
    // The remainder never exceeds 2q, so H+2 bits hold every intermediate.
    always_comb begin
        r_shift = {r[H-1:0], opnd[WIDTH-1 -: 2]};
        trial   = {q, 2'b01};
        if (r_shift >= trial) begin
            r_step = r_shift - trial;
            q_step = {q[H-2:0], 1'b1};
        end else begin
            r_step = r_shift;
            q_step = {q[H-2:0], 1'b0};
        end
    end

    // Final result shaping: round up when the remainder exceeds q, and clamp
    // instead of wrapping when q is already all ones.
    always_comb begin
        round_up = (ROUND != 0) && (r > {2'b00, q});
        sat_fin  = round_up && (&q);
        if (sat_fin) begin
            root_fin = '1;
        end else begin
            root_fin = q + {{(H-1){1'b0}}, round_up};
        end
    end

    // Datapath: operand shifter, working root/remainder, step counter and the
    // published results, which only change on a completed FIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            opnd      <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            bus.ROOT  <= '0;
            bus.REM   <= '0;
            bus.EXACT <= 1'b0;
            bus.SAT   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        opnd <= bus.OPERAND;
                        r    <= '0;
                        q    <= '0;
                        cnt  <= CNT_INIT;
                    end
                end
                S_ITER: begin
                    opnd <= {opnd[WIDTH-3:0], 2'b00};
                    r    <= r_step;
                    q    <= q_step;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    if (!bus.ABORT) begin
                        bus.ROOT  <= root_fin;
                        bus.REM   <= r[H:0];
                        bus.EXACT <= (r == '0);
                        bus.SAT   <= sat_fin;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_raiz_entera_param.sv
// Bench for the integer square-root unit at WIDTH=16, one instance per
// rounding mode sharing clock and reset. Drivers push the hand-computed
// result into a per-instance queue; the monitor pops on every DONE pulse.
module tb_raiz_entera_param;
    localparam int W  = 16;
    localparam int H  = W / 2;
    localparam int PW = H + (H + 1) + 2;

    logic       CLK;
    logic       RST;
    logic [1:0] st0;
    logic [1:0] st1;

    raiz_entera_param_if #(.WIDTH(W)) b0 ();
    raiz_entera_param_if #(.WIDTH(W)) b1 ();

    raiz_entera_param #(.WIDTH(W), .ROUND(0)) u0 (
        .CLK(CLK), .RST(RST), .bus(b0), .fsm_state(st0)
    );
    raiz_entera_param #(.WIDTH(W), .ROUND(1)) u1 (
        .CLK(CLK), .RST(RST), .bus(b1), .fsm_state(st1)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] exp_q0[$];
    logic [PW-1:0] exp_q1[$];
    longint        t_q0[$];
    longint        t_q1[$];

    function automatic logic [PW-1:0] pack(input logic [H-1:0] root, input logic [H:0] rem,
                                           input logic exact, input logic sat);
        return {root, rem, exact, sat};
    endfunction

    function automatic logic [PW-1:0] outs(input int sel);
        if (sel == 0) return {b0.ROOT, b0.REM, b0.EXACT, b0.SAT};
        return {b1.ROOT, b1.REM, b1.EXACT, b1.SAT};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input int sel, input logic s, input logic [W-1:0] op, input logic ab);
        if (sel == 0) begin
            b0.START = s; b0.OPERAND = op; b0.ABORT = ab;
        end else begin
            b1.START = s; b1.OPERAND = op; b1.ABORT = ab;
        end
    endtask

    task automatic do_start(input int sel, input logic [W-1:0] op, input logic ab,
                            input logic push, input logic [PW-1:0] exp);
        @(negedge CLK);
        drive(sel, 1'b1, op, ab);
        @(posedge CLK);
        if (push) begin
            if (sel == 0) begin exp_q0.push_back(exp); t_q0.push_back($time); end
            else          begin exp_q1.push_back(exp); t_q1.push_back($time); end
        end
        #1 drive(sel, 1'b0, op, 1'b0);
    endtask

    task automatic wait_done(input int sel);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = (sel == 0) ? b0.DONE : b1.DONE;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout dut%0d: got no DONE expected DONE within 40 cycles", sel);
        end
    endtask

    // Scoreboard monitor: result and latency on every DONE pulse
    always @(negedge CLK) begin
        if (!RST && b0.DONE) begin
            if (exp_q0.size() == 0) begin
                check("unexpected_done0", 32'd1, 32'd0);
            end else begin
                check("result0", 32'(outs(0)), 32'(exp_q0.pop_front()));
                check("latency0", 32'(($time - t_q0.pop_front() + 5) / 10), H + 2);
            end
        end
        if (!RST && b1.DONE) begin
            if (exp_q1.size() == 0) begin
                check("unexpected_done1", 32'd1, 32'd0);
            end else begin
                check("result1", 32'(outs(1)), 32'(exp_q1.pop_front()));
                check("latency1", 32'(($time - t_q1.pop_front() + 5) / 10), H + 2);
            end
        end
    end

    // Directed stimulus
    initial begin
        RST = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        repeat (3) @(negedge CLK);
        check("rst_out0", 32'(outs(0)), 32'd0);
        check("rst_out1", 32'(outs(1)), 32'd0);
        check("rst_busy_done0", {30'd0, b0.BUSY, b0.DONE}, 32'd0);
        check("rst_busy_done1", {30'd0, b1.BUSY, b1.DONE}, 32'd0);
        check("rst_state0", {30'd0, st0}, 32'd0);
        RST = 1'b0;

        // Zero operand, then observe the ITER encoding
        do_start(0, 16'd0, 1'b0, 1'b1, pack(8'd0, 9'd0, 1'b1, 1'b0));
        @(negedge CLK);
        check("iter_state0", {30'd0, st0}, 32'd1);
        check("iter_busy0", {31'd0, b0.BUSY}, 32'd1);
        wait_done(0);

        // Back-to-back: second START in the IDLE cycle right after DONE
        do_start(0, 16'd144, 1'b0, 1'b1, pack(8'd12, 9'd0, 1'b1, 1'b0));
        wait_done(0);
        do_start(0, 16'd65535, 1'b0, 1'b1, pack(8'd255, 9'd510, 1'b0, 1'b0));
        wait_done(0);

        // Round-to-nearest instance
        do_start(1, 16'd150, 1'b0, 1'b1, pack(8'd12, 9'd6, 1'b0, 1'b0));
        wait_done(1);
        do_start(1, 16'd157, 1'b0, 1'b1, pack(8'd13, 9'd13, 1'b0, 1'b0));
        wait_done(1);
        // ABORT while in DONE is ignored
        drive(1, 1'b0, '0, 1'b1);
        @(negedge CLK);
        drive(1, 1'b0, '0, 1'b0);
        check("abort_in_done_state1", {30'd0, st1}, 32'd0);
        check("abort_in_done_out1", 32'(outs(1)), 32'(pack(8'd13, 9'd13, 1'b0, 1'b0)));
        do_start(1, 16'd65535, 1'b0, 1'b1, pack(8'd255, 9'd510, 1'b0, 1'b1));
        wait_done(1);
        // START with ABORT in IDLE is accepted
        do_start(1, 16'd144, 1'b1, 1'b1, pack(8'd12, 9'd0, 1'b1, 1'b0));
        wait_done(1);

        // Abort in the 4th ITER cycle: no DONE, results untouched
        do_start(0, 16'd144, 1'b0, 1'b0, '0);
        repeat (4) @(negedge CLK);
        check("pre_abort_state0", {30'd0, st0}, 32'd1);
        drive(0, 1'b0, '0, 1'b1);
        @(negedge CLK);
        drive(0, 1'b0, '0, 1'b0);
        check("abort_busy0", {31'd0, b0.BUSY}, 32'd0);
        check("abort_out0", 32'(outs(0)), 32'(pack(8'd255, 9'd510, 1'b0, 1'b0)));
        repeat (15) @(negedge CLK);
        check("abort_hold0", 32'(outs(0)), 32'(pack(8'd255, 9'd510, 1'b0, 1'b0)));

        // START pulsed while busy is neither queued nor recaptured
        do_start(0, 16'd150, 1'b0, 1'b1, pack(8'd12, 9'd6, 1'b0, 1'b0));
        repeat (2) @(negedge CLK);
        drive(0, 1'b1, 16'd9999, 1'b0);
        repeat (3) @(negedge CLK);
        drive(0, 1'b0, 16'd0, 1'b0);
        wait_done(0);
        drive(0, 1'b1, 16'd4, 1'b0);
        @(negedge CLK);
        drive(0, 1'b0, 16'd0, 1'b0);
        check("start_in_done_state0", {30'd0, st0}, 32'd0);
        repeat (15) @(negedge CLK);

        // Reset during ITER discards the operation
        do_start(0, 16'd65535, 1'b0, 1'b0, '0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_out0", 32'(outs(0)), 32'd0);
        check("midrst_out1", 32'(outs(1)), 32'd0);
        check("midrst_busy0", {31'd0, b0.BUSY}, 32'd0);
        check("midrst_state0", {30'd0, st0}, 32'd0);
        repeat (15) @(negedge CLK);

        // Recovery and small-operand rounding boundaries
        do_start(0, 16'd1, 1'b0, 1'b1, pack(8'd1, 9'd0, 1'b1, 1'b0));
        wait_done(0);
        do_start(1, 16'd2, 1'b0, 1'b1, pack(8'd1, 9'd1, 1'b0, 1'b0));
        wait_done(1);
        do_start(1, 16'd3, 1'b0, 1'b1, pack(8'd2, 9'd2, 1'b0, 1'b0));
        wait_done(1);

        repeat (3) @(negedge CLK);
        check("queue_empty0", 32'(exp_q0.size()), 32'd0);
        check("queue_empty1", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/raiz_entera_param.md
RAIZ_ENTERA_PARAM -- requirements
Module: raiz_entera_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning radicand width in bits; legal values are even integers from 4 to 32.
REQ-002 SHALL provide parameter ROUND, default 0, meaning root mode: 0 = floor(sqrt), 1 = round-to-nearest.
REQ-003 SHALL provide port CLK  input  1  system clock; all logic is rising-edge triggered.
REQ-004 SHALL provide port RST  input  1  reset, synchronous, active-high, single clock domain.
REQ-005 SHALL provide port START  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 SHALL provide port OPERAND  input  WIDTH  unsigned radicand; captured in the START cycle.
REQ-007 SHALL provide port ABORT  input  1  cancels an operation in progress.
REQ-008 SHALL provide port BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL provide port DONE  output  1  one-cycle pulse when ROOT, REM, EXACT and SAT update.
REQ-010 SHALL provide port ROOT  output  WIDTH/2  result root.
REQ-011 SHALL provide port REM  output  WIDTH/2+1  floor remainder, OPERAND - floor_root^2.
REQ-012 SHALL provide port EXACT  output  1  set when REM = 0.
REQ-013 SHALL provide port SAT  output  1  set when rounding overflowed and ROOT saturated.

Function
REQ-014 SHALL implement the FSM states IDLE, ITER, FIN and DONE with the fixed encoding IDLE=00, ITER=01, FIN=10, DONE=11.
REQ-015 SHALL, in IDLE with START=1, capture OPERAND, clear the working root and remainder, load iteration counter = WIDTH/2-1, and go to ITER.
REQ-016 SHALL execute one radix-4 restoring step per ITER cycle, consuming operand bit pairs MSB-first:
  - r' = (r<<2) | next pair
  - t = (q<<2) | 1
  - if r' >= t: r = r' - t and q = (q<<1)|1; else r = r' and q = q<<1
REQ-017 SHALL size the working remainder and the trial value at WIDTH/2+2 bits so that no intermediate overflows.
REQ-018 SHALL go from ITER to FIN after the step in which the counter equals 0; the counter decrements once per step.
REQ-019 SHALL, in FIN, register the outputs and go to DONE:
  - ROOT = q when ROUND=0
  - when ROUND=1: ROOT = q+1 if r > q, otherwise q
REQ-020 SHALL, when ROUND=1 and q = 2^(WIDTH/2)-1 and r > q, set ROOT to all ones and SAT=1; otherwise SAT=0.
REQ-021 SHALL report REM as the floor remainder r and EXACT as (r == 0) regardless of ROUND.
REQ-022 SHALL assert DONE for exactly the one cycle spent in DONE, then return to IDLE.
REQ-023 SHALL assert DONE WIDTH/2+2 cycles after the START-sampling edge (10 cycles for WIDTH=16).
REQ-024 SHALL hold ROOT, REM, EXACT and SAT stable between FIN updates, including through an aborted operation.
REQ-025 SHALL ignore START in ITER, FIN and DONE; it is neither queued nor flagged.
REQ-026 SHALL, with ABORT=1 in ITER or FIN, go to IDLE on the next edge with no DONE and no output update.
REQ-027 SHALL ignore ABORT in IDLE and in DONE; DONE completes normally.
REQ-028 SHALL, when ABORT and START are both high in IDLE, accept START.
REQ-029 SHALL accept START in the IDLE cycle that directly follows DONE, giving back-to-back operation.

Reset
REQ-030 SHALL, on RST=1 at a rising edge, set the state to IDLE and set BUSY=0, DONE=0, ROOT=0, REM=0, EXACT=0, SAT=0, counter=0.
REQ-031 SHALL, on RST mid-operation, discard the operation with no DONE; RST has priority over START and ABORT.

Verification (WIDTH=16)
REQ-032 SHALL cover: ROUND=0, OPERAND=0 -> DONE at cycle 10, ROOT=0, REM=0, EXACT=1, SAT=0.
REQ-033 SHALL cover: ROUND=0, OPERAND=144 then OPERAND=65535 back-to-back -> ROOT=12, REM=0, EXACT=1; then ROOT=255, REM=510, EXACT=0.
REQ-034 SHALL cover: ROUND=1, OPERAND=150 -> ROOT=12, REM=6; ROUND=1, OPERAND=157 -> ROOT=13, REM=13.
REQ-035 SHALL cover: ROUND=1, OPERAND=65535 -> ROOT=255, SAT=1, REM=510, EXACT=0.
REQ-036 SHALL cover: START with OPERAND=144, ABORT in the 4th ITER cycle -> BUSY falls next cycle, no DONE, previous outputs unchanged.
REQ-037 SHALL cover: RST during ITER, and START pulsed while BUSY -> RST: all outputs zero, no DONE; START while BUSY: exactly one DONE for the original operand.
